// File: rtl/sparse_code_tx.sv
// sparse_code_tx: streams the sparse 3-bit code set in ascending order over a
// valid/ready handshake for NUM_ROUNDS passes per start request. Each pass
// covers 000, 001, 010, 100 and 101.
// Optional build macro SPARSE_CODE_TX_ILLEGAL_EN: when it is defined, each
// pass covers all eight codes, and code_illegal_o flags 011, 110 and 111.
module sparse_code_tx #(
  parameter int unsigned NUM_ROUNDS = 1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  output logic [2:0] code_o,
  output logic       code_valid_o,
  input  logic       code_ready_i,
  output logic       code_illegal_o,
  output logic [7:0] round_o,
  output logic       busy_o,
  output logic       done_o
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 255 || GAP_CYCLES > 15) begin : g_param_check
    $error("sparse_code_tx: NUM_ROUNDS must be 1..255 and GAP_CYCLES 0..15");
  end

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t     state;
  logic [3:0] gap_cnt;
  logic [2:0] next_code;
  logic       wrap;
  logic [7:0] next_round;
  logic       last_round;

`ifdef SPARSE_CODE_TX_ILLEGAL_EN
  logic next_illegal;

  // Successor in the full 8-code sequence; the round wraps after 111.
  always_comb begin
    next_code    = code_o + 3'd1;
    wrap         = (code_o == 3'b111);
    next_illegal = (next_code == 3'b011) || (next_code == 3'b110) || (next_code == 3'b111);
  end
`else
  // Successor in the legal sparse sequence; the round wraps after 101.
  always_comb begin
    next_code = 3'b000;
    wrap      = 1'b0;
    unique case (code_o)
      3'b000:  next_code = 3'b001;
      3'b001:  next_code = 3'b010;
      3'b010:  next_code = 3'b100;
      3'b100:  next_code = 3'b101;
      default: begin
        next_code = 3'b000;
        wrap      = 1'b1;
      end
    endcase
  end

  assign code_illegal_o = 1'b0;
`endif

  // Round bookkeeping derived from the code currently presented.
  always_comb begin
    next_round = wrap ? round_o + 8'd1 : round_o;
    last_round = (round_o == 8'(NUM_ROUNDS - 1));
  end

  // Control FSM. All outputs are registered. During GAP, the current code and
  // round are held. The next code and round are loaded only on return to SEND,
  // so round_o changes in the same cycle as the first beat of the new round.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      code_o       <= '0;
      code_valid_o <= 1'b0;
      round_o      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      gap_cnt      <= '0;
`ifdef SPARSE_CODE_TX_ILLEGAL_EN
      code_illegal_o <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state        <= SEND;
            code_o       <= '0;
            code_valid_o <= 1'b1;
            busy_o       <= 1'b1;
            round_o      <= '0;
`ifdef SPARSE_CODE_TX_ILLEGAL_EN
            code_illegal_o <= 1'b0;
`endif
          end
        end
        SEND: begin
          if (code_ready_i) begin
            if (wrap && last_round) begin
              state        <= DONE;
              code_valid_o <= 1'b0;
              busy_o       <= 1'b0;
              done_o       <= 1'b1;
            end else if (GAP_CYCLES == 0) begin
              code_o  <= next_code;
              round_o <= next_round;
`ifdef SPARSE_CODE_TX_ILLEGAL_EN
              code_illegal_o <= next_illegal;
`endif
            end else begin
              state        <= GAP;
              code_valid_o <= 1'b0;
              gap_cnt      <= 4'(GAP_CYCLES);
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt == 4'd1) begin
            state        <= SEND;
            code_valid_o <= 1'b1;
            code_o       <= next_code;
            round_o      <= next_round;
`ifdef SPARSE_CODE_TX_ILLEGAL_EN
            code_illegal_o <= next_illegal;
`endif
          end
        end
        DONE: begin
          state   <= IDLE;
          done_o  <= 1'b0;
          round_o <= '0;
          code_o  <= '0;
`ifdef SPARSE_CODE_TX_ILLEGAL_EN
          code_illegal_o <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sparse_code_tx.md
Name: sparse_code_tx

Overview:
- Transmit-side counterpart to the sparse 3-bit code decoders in the design.
- On a start pulse, emits the legal code set {000, 001, 010, 100, 101} in ascending order over a valid/ready stream, repeated for a configurable number of rounds.
- Downstream case/if decoders consume the stream. An optional mode also emits the illegal codes so decoder default paths are exercised.

Parameters:
- NUM_ROUNDS, 1: number of full passes over the code set per start; legal range 1..255.
- GAP_CYCLES, 0: idle cycles (valid low) inserted after each accepted beat; legal range 0..15.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  start request; sampled only in IDLE.
- code_o  output  3  current code.
- code_valid_o  output  1  code_o is valid.
- code_ready_i  input  1  consumer accepts code_o.
- code_illegal_o  output  1  code_o is outside the legal set; qualified by code_valid_o.
- round_o  output  8  index of the round in progress, 0-based.
- busy_o  output  1  high from the cycle after start until done.
- done_o  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (async assert, sync release): state=IDLE; code_o=000; code_valid_o=0; code_illegal_o=0; round_o=0; busy_o=0; done_o=0; gap counter=0.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start_i=1 at edge t → SEND; code_o=000, code_valid_o=1, busy_o=1 in cycle t+1.
  - start_i=0 → stay in IDLE.
- SEND:
  - Beat accepted at an edge where code_valid_o && code_ready_i.
  - Until acceptance, code_o, code_illegal_o and round_o are held stable and code_valid_o is never deasserted.
  - On acceptance, the next position in the code sequence is computed:
    - Not last beat of last round, GAP_CYCLES=0 → stay in SEND; next code presented in the next cycle (back-to-back, one beat per cycle at full throughput).
    - Not last beat of last round, GAP_CYCLES>0 → GAP; code_valid_o=0; gap counter loaded with GAP_CYCLES.
    - Last beat of round NUM_ROUNDS-1 → DONE; code_valid_o=0.
- GAP:
  - Gap counter decrements each cycle; code_valid_o=0.
  - When the counter reaches 1 → SEND, presenting the next code.
  - Exactly GAP_CYCLES valid-low cycles between beats.
- Round wrap:
  - After code 101 is accepted (legal mode), the sequence restarts at 000 and round_o increments.
  - round_o changes in the same cycle the first beat of the new round is presented, never earlier.
- DONE:
  - done_o=1 and busy_o=0 for exactly one cycle.
  - Next state IDLE; round_o returns to 0 on entry to IDLE.
- Ignored inputs:
  - start_i is ignored in SEND, GAP and DONE; no restart, no queuing.
  - code_ready_i is ignored while code_valid_o=0.
- Reset mid-transfer: all outputs return to their reset values immediately. No partial completion and no done_o pulse.
- Parameter checks: NUM_ROUNDS=0 or GAP_CYCLES>15 is rejected by an elaboration-time assertion.

Optional Feature:
- SPARSE_CODE_TX_ILLEGAL_EN defined:
  - Sequence is all eight codes 000..111 ascending; round wrap occurs after 111.
  - code_illegal_o=1 while code_o is 011, 110 or 111; 0 otherwise.
- Undefined:
  - Sequence is the 5 legal codes only; code_illegal_o is tied to 0.
  - The illegal values are never driven on code_o.

Test Plan:
- Defaults, code_ready_i=1, start pulse at cycle 2 → valid cycles 3..7 with codes 000,001,010,100,101; done_o=1 at cycle 8 only; busy_o high cycles 3..7.
- code_ready_i=0 for 4 cycles while code_o=010 → code_o stays 010 and valid stays 1 for all 4 cycles; 100 appears the cycle after ready rises.
- GAP_CYCLES=2, NUM_ROUNDS=2, ready=1 → 10 beats, 2 valid-low cycles after each of the first 9; round_o=1 from the 6th beat (000); single done_o pulse.
- start_i pulsed during SEND and during DONE → no effect; exactly 5 beats and one done_o pulse.
- rst_ni low while code_o=100 is pending → code_valid_o, busy_o and round_o drop to 0 asynchronously; after release, a new start sends from 000.
- SPARSE_CODE_TX_ILLEGAL_EN, ready=1 → 8 beats 000..111; code_illegal_o high exactly on beats 011, 110 and 111.
